md_sixbutton_reader: RTL and testbench

- Console-side reader for the Mega Drive six-button pad protocol; the counterpart of md_sixbutton_encoder.
- Drives the select line (DB9 pin 7, TH) through an 8-phase sequence and samples pins 1,2,3,4,6,9.
- Decodes pad presence, three- vs six-button type, and 12 button states.
- Publishes one atomic snapshot per frame for the host/FPGA core (e.g. a MiSTer-style core or a USB bridge).

---
 rtl/md_sixbutton_reader.sv | 210 +++++++++++++++++++++
 tb/tb_md_sixbutton_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_sixbutton_reader.sv
// ---------------------------------------------------------------------------
// md_sixbutton_reader
//
// Console-side reader for the Mega Drive six-button pad protocol. Once per
// poll period it drives the select line (TH, DB9 pin 7) through eight half
// periods (high/low alternating, starting high). It samples the pad pins at
// the end of selected phases and publishes one atomic snapshot of presence,
// pad type and the twelve button states.
//
// Ports:
//   clk      system clock (20 MHz nominal)
//   rst      asynchronous, active-high reset
//   en       polling enable; a frame that has started always completes
//   p1..p9   DB9 pins 1,2,3,4,6,9 from the pad (active-low buttons)
//   p7       DB9 pin 7 select (TH) to the pad
//   btn      pressed=1, {md,x,y,z,st,a,c,b,rg,lf,dw,up} (bit 11..0)
//   present  pad detected in the last frame
//   six      six-button pad detected in the last frame
//   valid    one-cycle pulse when btn/present/six update
//
// Parameters:
//   HALF_PERIOD_CYCLES  clk cycles per TH phase (>= 4)
//   POLL_CYCLES         clk cycles between frame starts
//                       (> 8*HALF_PERIOD_CYCLES+4)
//
// Optional feature (macro MD_READER_SYNC_EN):
//   defined   - pad pins pass through a 2-FF synchronizer (reset value 1)
//   undefined - pad pins are sampled directly (pre-synchronized inputs)
// ---------------------------------------------------------------------------
module md_sixbutton_reader #(
    parameter int HALF_PERIOD_CYCLES = 200,
    parameter int POLL_CYCLES        = 333333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        p1,
    input  logic        p2,
    input  logic        p3,
    input  logic        p4,
    input  logic        p6,
    input  logic        p9,
    output logic        p7,
    output logic [11:0] btn,
    output logic        present,
    output logic        six,
    output logic        valid
);

    localparam int HW = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    // Bit positions of the pins inside the packed pin vectors.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P3 = 2;
    localparam int P4 = 3;
    localparam int P6 = 4;
    localparam int P9 = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    logic [5:0] pins_raw;
    logic [5:0] pins_s;

    assign pins_raw = {p9, p6, p4, p3, p2, p1};

`ifdef MD_READER_SYNC_EN
    // Two-stage synchronizer; idle value 1 matches released (unpressed) pins.
    // The extra latency is hidden because sampling happens at phase end.
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = pins_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pins_s = sync2_q;
`else
    assign pins_s = pins_raw;
`endif

    state_e        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [HW-1:0] cnt_q,   cnt_d;
    logic [PW-1:0] poll_q,  poll_d;
    logic [11:0]   shadow_q, shadow_d;
    logic          pres_q,  pres_d;
    logic          id6_q,   id6_d;
    logic [11:0]   btn_q,   btn_d;
    logic          present_q, present_d;
    logic          six_q,   six_d;

    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        pres_d    = pres_q;
        id6_d     = id6_q;
        btn_d     = btn_q;
        present_d = present_q;
        six_d     = six_q;

        // Free-running poll timer, independent of the frame FSM.
        poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (en && poll_q == '0) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            end

            S_RUN: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    phase_d = phase_q + 3'd1;
                    case (phase_q)
                        // TH=1: {c,b,rg,lf,dw,up} on p9,p6,p4,p3,p2,p1.
                        3'd0: shadow_d[5:0] = ~pins_s;
                        // TH=0: A/Start, and p3=p4=0 marks a connected pad.
                        3'd1: begin
                            shadow_d[6] = ~pins_s[P6];
                            shadow_d[7] = ~pins_s[P9];
                            pres_d      = ~pins_s[P3] & ~pins_s[P4];
                        end
                        // Third TH low: a six-button pad pulls p1..p4 all low.
                        3'd5: id6_d = (pins_s[P4:P1] == 4'b0000);
                        // TH=1 after the ID phase: {md,x,y,z} on p4..p1.
                        3'd6: shadow_d[11:8] = ~{pins_s[P4], pins_s[P3], pins_s[P2], pins_s[P1]};
                        3'd7: begin
                            state_d   = S_DONE;
                            present_d = pres_q;
                            six_d     = pres_q & id6_q;
                            // Extended buttons are only meaningful on a six-button pad.
                            btn_d     = pres_q ? {(id6_q ? shadow_q[11:8] : 4'b0000), shadow_q[7:0]}
                                               : 12'h000;
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            poll_q    <= '0;
            shadow_q  <= '0;
            pres_q    <= 1'b0;
            id6_q     <= 1'b0;
            btn_q     <= '0;
            present_q <= 1'b0;
            six_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            shadow_q  <= shadow_d;
            pres_q    <= pres_d;
            id6_q     <= id6_d;
            btn_q     <= btn_d;
            present_q <= present_d;
            six_q     <= six_d;
        end
    end

    // TH is decoded from registered state only, so reset forces it high
    // asynchronously and it stays high in IDLE and DONE.
    assign p7      = !((state_q == S_RUN) && phase_q[0]);
    assign valid   = (state_q == S_DONE);
    assign btn     = btn_q;
    assign present = present_q;
    assign six     = six_q;

endmodule

// File: tb/tb_md_sixbutton_reader.sv
// ---------------------------------------------------------------------------
// tb_md_sixbutton_reader
//
// Drives md_sixbutton_reader with a behavioural pad (none / three-button /
// six-button) that reacts to TH. Expected snapshots are queued by the
// stimulus; a monitor pops and compares on every valid pulse and also checks
// the TH waveform (four lows of HALF_PERIOD_CYCLES per frame).
// ---------------------------------------------------------------------------
module tb_md_sixbutton_reader;

    localparam int H    = 4;
    localparam int POLL = 80;
    localparam int FRAME_LAT = 8 * H + 1;

    typedef enum logic [1:0] {PAD_NONE, PAD_THREE, PAD_SIX} pad_e;

    typedef struct {
        pad_e        kind;
        logic [11:0] pressed;
        logic [13:0] exp;     // {present, six, btn}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [5:0]  pins;        // {p9,p6,p4,p3,p2,p1}
    logic        p7;
    logic [11:0] btn;
    logic        present;
    logic        six;
    logic        valid;

    pad_e        pad_kind = PAD_NONE;
    logic [11:0] pad_btn  = 12'h000;
    int          low_cnt  = 0;

    int checks = 0;
    int errors = 0;
    logic [13:0] sb[$];

    md_sixbutton_reader #(
        .HALF_PERIOD_CYCLES(H),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .p1(pins[0]),
        .p2(pins[1]),
        .p3(pins[2]),
        .p4(pins[3]),
        .p6(pins[4]),
        .p9(pins[5]),
        .p7(p7),
        .btn(btn),
        .present(present),
        .six(six),
        .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pad model: counts TH falling edges in the current frame.
    initial begin
        logic p7_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || valid) low_cnt = 0;
            else if (p7_prev && !p7) low_cnt = low_cnt + 1;
            p7_prev = p7;
        end
    end

    always_comb begin
        pins = 6'h3F;
        if (pad_kind != PAD_NONE) begin
            if (p7) begin
                if (pad_kind == PAD_SIX && low_cnt == 3)
                    pins = ~{pad_btn[5], pad_btn[4], pad_btn[11], pad_btn[10], pad_btn[9], pad_btn[8]};
                else
                    pins = ~pad_btn[5:0];
            end else begin
                if (pad_kind == PAD_SIX && low_cnt == 3)
                    pins = {~pad_btn[7], ~pad_btn[6], 4'b0000};
                else if (pad_kind == PAD_SIX && low_cnt == 4)
                    pins = {~pad_btn[7], ~pad_btn[6], 4'b1111};
                else
                    pins = {~pad_btn[7], ~pad_btn[6], 2'b00, ~pad_btn[1], ~pad_btn[0]};
            end
        end
    end

    // Monitor: TH low-run lengths, lows per frame, and snapshot scoreboard.
    initial begin
        int   low_run = 0;
        int   lows    = 0;
        logic prev    = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_run = 0;
                lows    = 0;
                prev    = 1'b1;
            end else begin
                if (!p7) begin
                    low_run++;
                end else if (!prev) begin
                    check("p7_low_len", low_run, H);
                    lows++;
                    low_run = 0;
                end
                if (valid) begin
                    check("p7_lows_per_frame", lows, 4);
                    lows = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got {present,six,btn}=%0h with no expected entry",
                                 {present, six, btn});
                    end else begin
                        check("frame", {18'h0, present, six, btn}, {18'h0, sb.pop_front()});
                    end
                end
                prev = p7;
            end
        end
    end

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 4 * POLL);
        check({name, "_timeout"}, {31'h0, valid}, 32'h1);
    endtask

    task automatic wait_p7(input logic lvl, input string name);
        int n = 0;
        while (p7 !== lvl && n < 4 * POLL) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'h0, p7}, {31'h0, lvl});
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        int   bad;

        vecs[0] = '{PAD_THREE, 12'h0C0, {2'b10, 12'h0C0}};  // A + Start
        vecs[1] = '{PAD_SIX,   12'hC00, {2'b11, 12'hC00}};  // X + Mode
        vecs[2] = '{PAD_SIX,   12'hA00, {2'b11, 12'hA00}};  // Y + Mode
        vecs[3] = '{PAD_SIX,   12'hFFF, {2'b11, 12'hFFF}};  // everything
        vecs[4] = '{PAD_THREE, 12'hF29, {2'b10, 12'h029}};  // extended bits must drop
        vecs[5] = '{PAD_SIX,   12'h029, {2'b11, 12'h029}};  // Up + Right + C

        // Reset state.
        sb.push_back({2'b00, 12'h000});                     // no pad
        repeat (3) @(negedge clk);
        check("rst_p7", {31'h0, p7}, 32'h1);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_btn", {20'h0, btn}, 32'h0);
        check("rst_present", {31'h0, present}, 32'h0);
        check("rst_six", {31'h0, six}, 32'h0);

        // First frame starts right after reset release.
        rst = 1'b0;
        wait_valid("first_frame", n);
        check("first_frame_latency", n, FRAME_LAT);

        for (int i = 0; i < 6; i++) begin
            pad_kind = vecs[i].kind;
            pad_btn  = vecs[i].pressed;
            sb.push_back(vecs[i].exp);
            wait_valid("vec", n);
        end

        // en dropped during phase 2: the frame still completes.
        pad_kind = PAD_THREE;
        pad_btn  = 12'h010;                                 // B
        sb.push_back({2'b10, 12'h010});
        wait_p7(1'b0, "en_frame_start");
        repeat (H) @(negedge clk);
        en = 1'b0;
        wait_valid("en_low_frame", n);
        bad = 0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(negedge clk);
            if (valid || !p7) bad++;
        end
        check("en_low_quiet", bad, 0);

        // Reset in phase 3 aborts the frame; a fresh one follows release.
        pad_kind = PAD_SIX;
        pad_btn  = 12'h029;
        en = 1'b1;
        wait_p7(1'b0, "rst_ph1");
        wait_p7(1'b1, "rst_ph2");
        wait_p7(1'b0, "rst_ph3");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_p7", {31'h0, p7}, 32'h1);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_btn", {20'h0, btn}, 32'h0);
        check("midrst_present", {31'h0, present}, 32'h0);
        check("midrst_six", {31'h0, six}, 32'h0);
        repeat (3) @(negedge clk);
        sb.push_back({2'b11, 12'h029});
        rst = 1'b0;
        wait_valid("after_rst_frame", n);
        check("after_rst_latency", n, FRAME_LAT);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
